// File: rtl/collision_scheduler.sv
// collision_scheduler
//   Time-multiplexes one shared bubble-sprite ROM and one collision evaluator
//   across all bubbles. Each `start` takes a snapshot of the swimmer/bubble
//   positions and scans bubbles 0..BUBBLES-1 in order, spending three cycles
//   per bubble (issue address, ROM access, evaluate). The result is published
//   as a registered vector together with a one-cycle `done` pulse.
//
// Ports:
//   clock       system clock, rising edge
//   resetn      asynchronous active-low reset
//   start       scan request, only honoured while idle
//   swimmerX/Y  swimmer origin
//   bubbleX/Y   packed bubble origins (bubble i at [8i+7:8i] / [7i+6:7i])
//   bubble_en   per-bubble enable; disabled bubbles never collide
//   rom_address registered address to the shared synchronous sprite ROM
//   rom_data    ROM colour, valid one cycle after the ROM samples the address
//   busy        high while a scan is in progress, drops together with done
//   done        one-cycle pulse, collisionBS updates in the same cycle
//   collisionBS bit i set when the swimmer centre is on an opaque pixel of bubble i
`timescale 1ns/1ps

module collision_scheduler #(
    parameter int unsigned BUBBLES = 7,
    parameter int unsigned BSIZE   = 28,
    parameter int unsigned CX_OFF  = 4,
    parameter int unsigned CY_OFF  = 9,
    parameter logic [2:0]  TRANSP  = 3'b101
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [7:0]           swimmerX,
    input  logic [6:0]           swimmerY,
    input  logic [8*BUBBLES-1:0] bubbleX,
    input  logic [7*BUBBLES-1:0] bubbleY,
    input  logic [BUBBLES-1:0]   bubble_en,
    output logic [9:0]           rom_address,
    input  logic [2:0]           rom_data,
    output logic                 busy,
    output logic                 done,
    output logic [BUBBLES-1:0]   collisionBS
);

    localparam int unsigned IDXW = (BUBBLES > 1) ? $clog2(BUBBLES) : 1;
    localparam logic signed [9:0] CXO     = 10'(CX_OFF);
    localparam logic signed [9:0] CYO     = 10'(CY_OFF);
    localparam logic signed [9:0] BMAX    = 10'(BSIZE - 1);
    localparam logic [9:0]        BSZ     = 10'(BSIZE);
    localparam logic [IDXW-1:0]   LASTIDX = IDXW'(BUBBLES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, DONE} state_t;

    state_t state, stateNext;

    logic [7:0]           snapSwX;
    logic [6:0]           snapSwY;
    logic [8*BUBBLES-1:0] snapBX;
    logic [7*BUBBLES-1:0] snapBY;
    logic [BUBBLES-1:0]   snapEn;
    logic [IDXW-1:0]      idx;
    logic [BUBBLES-1:0]   shadow;
    logic                 inbox;

    logic [7:0]        curBX;
    logic [6:0]        curBY;
    logic              curEn;
    logic signed [9:0] cx, cy, dx, dy;
    logic              inboxNext;
    logic [9:0]        addrNext;

    // Offsets are formed in 10-bit signed arithmetic so a swimmer at the right
    // edge (X=255) yields cx=259 instead of wrapping back into a bubble.
    always_comb begin
        curBX     = snapBX[int'(idx)*8 +: 8];
        curBY     = snapBY[int'(idx)*7 +: 7];
        curEn     = snapEn[idx];
        cx        = $signed({2'b00, snapSwX}) + CXO;
        cy        = $signed({3'b000, snapSwY}) + CYO;
        dx        = cx - $signed({2'b00, curBX});
        dy        = cy - $signed({3'b000, curBY});
        inboxNext = curEn && !dx[9] && (dx <= BMAX) && !dy[9] && (dy <= BMAX);
        addrNext  = inboxNext ? ($unsigned(dy) * BSZ + $unsigned(dx)) : '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = ISSUE;
            ISSUE:   stateNext = WAIT;
            WAIT:    stateNext = EVAL;
            EVAL:    stateNext = (idx == LASTIDX) ? DONE : ISSUE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rom_address <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            collisionBS <= '0;
            shadow      <= '0;
            idx         <= '0;
            inbox       <= 1'b0;
            snapSwX     <= '0;
            snapSwY     <= '0;
            snapBX      <= '0;
            snapBY      <= '0;
            snapEn      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snapSwX <= swimmerX;
                        snapSwY <= swimmerY;
                        snapBX  <= bubbleX;
                        snapBY  <= bubbleY;
                        snapEn  <= bubble_en;
                        idx     <= '0;
                        shadow  <= '0;
                        busy    <= 1'b1;
                    end
                end
                ISSUE: begin
                    inbox       <= inboxNext;
                    rom_address <= addrNext;
                end
                EVAL: begin
                    shadow[idx] <= inbox && (rom_data != TRANSP);
                    if (idx != LASTIDX) begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    collisionBS <= shadow;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scheduler.sv
`timescale 1ns/1ps

module tb_collision_scheduler;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  swimmerX = '0;
    logic [6:0]  swimmerY = '0;
    logic [55:0] bubbleX = '0;
    logic [48:0] bubbleY = '0;
    logic [6:0]  bubble_en = '0;
    logic [9:0]  rom_address;
    logic [2:0]  rom_data = '0;
    logic        busy;
    logic        done;
    logic [6:0]  collisionBS;

    collision_scheduler #(
        .BUBBLES(7),
        .BSIZE(28),
        .CX_OFF(4),
        .CY_OFF(9),
        .TRANSP(3'b101)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .start(start),
        .swimmerX(swimmerX),
        .swimmerY(swimmerY),
        .bubbleX(bubbleX),
        .bubbleY(bubbleY),
        .bubble_en(bubble_en),
        .rom_address(rom_address),
        .rom_data(rom_data),
        .busy(busy),
        .done(done),
        .collisionBS(collisionBS)
    );

    always #5 clock = ~clock;

    // Synchronous sprite ROM model.
    logic [2:0] rom [784];
    always @(posedge clock) rom_data <= (rom_address < 10'd784) ? rom[rom_address] : 3'b000;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] baseRom(input int a);
        return (a % 9 == 4) ? 3'b101 : 3'(a % 4);
    endfunction

    function automatic logic [55:0] pk8(input int a0, a1, a2, a3, a4, a5, a6);
        return {8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [48:0] pk7(input int a0, a1, a2, a3, a4, a5, a6);
        return {7'(a6), 7'(a5), 7'(a4), 7'(a3), 7'(a2), 7'(a1), 7'(a0)};
    endfunction

    // Scene as plain integers; this is what the reference model reasons about.
    int         sxI, syI;
    int         bxI [7];
    int         byI [7];
    logic [6:0] enI;

    function automatic bit modelIn(input int i);
        int dx, dy;
        dx = sxI + 4 - bxI[i];
        dy = syI + 9 - byI[i];
        return enI[i] && dx >= 0 && dx < 28 && dy >= 0 && dy < 28;
    endfunction

    function automatic int modelAddr(input int i);
        if (!modelIn(i)) return 0;
        return (syI + 9 - byI[i]) * 28 + (sxI + 4 - bxI[i]);
    endfunction

    function automatic logic [6:0] modelVec();
        logic [6:0] v;
        v = '0;
        for (int i = 0; i < 7; i++) v[i] = modelIn(i) && (rom[modelAddr(i)] != 3'b101);
        return v;
    endfunction

    task automatic drive();
        swimmerX  = 8'(sxI);
        swimmerY  = 7'(syI);
        for (int i = 0; i < 7; i++) begin
            bubbleX[8*i +: 8] = 8'(bxI[i]);
            bubbleY[7*i +: 7] = 7'(byI[i]);
        end
        bubble_en = enI;
    endtask

    logic [9:0] seenAddr [7];
    int         seenLat;
    logic [6:0] seenVec;

    // One scan: start is accepted at edge 0; bubble i's address is visible
    // after edge 3i+1; done is expected after edge 22.
    task automatic doScan(input bit pulseMid, input bit scramble);
        int extra;
        int busyDrops;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (scramble) begin
            swimmerX  = 8'($urandom);
            swimmerY  = 7'($urandom);
            bubbleX   = 56'({$urandom, $urandom});
            bubbleY   = 49'({$urandom, $urandom});
            bubble_en = 7'($urandom);
        end
        check("busy_after_accept", 32'(busy), 1);
        seenLat   = 0;
        busyDrops = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (k % 3 == 1 && k <= 19) seenAddr[(k - 1) / 3] = rom_address;
            if (done) begin
                seenLat = k;
                break;
            end
            if (!busy) busyDrops++;
            start = pulseMid && (k == 10 || k == 21);
        end
        start   = 1'b0;
        seenVec = collisionBS;
        check("done_latency", seenLat, 22);
        check("busy_held_during_scan", busyDrops, 0);
        if (seenLat != 0) check("busy_low_in_done_cycle", 32'(busy), 0);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock);
            #1;
            if (done || busy) extra++;
        end
        check("no_extra_done_or_busy", extra, 0);
        check("result_held", 32'(collisionBS), 32'(seenVec));
    endtask

    typedef struct {
        int         sx;
        int         sy;
        logic [55:0] bx;
        logic [48:0] by;
        logic [6:0] en;
        int         romAddr;
        logic [2:0] romVal;
        int         chkBub;
        int         chkAddr;
        logic [6:0] expVec;
    } vec_t;

    vec_t tbl [10];
    vec_t v;

    task automatic loadVec(input vec_t x);
        sxI = x.sx;
        syI = x.sy;
        enI = x.en;
        for (int i = 0; i < 7; i++) begin
            bxI[i] = int'(x.bx[8*i +: 8]);
            byI[i] = int'(x.by[7*i +: 7]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 784; a++) rom[a] = baseRom(a);

        #12;
        check("reset_rom_address", 32'(rom_address), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_collisionBS", 32'(collisionBS), 0);
        @(negedge clock);
        resetn = 1'b1;

        //         sx   sy   bubbleX                                bubbleY                                 en         romA romV    chk  addr  expected
        tbl[0] = '{20,  20, pk8(10,200,200,200,200,200,200),  pk7(20,100,100,100,100,100,100),  7'h7f,      266, 3'b010, 0, 266, 7'b0000001};
        tbl[1] = '{20,  20, pk8(10,200,200,200,200,200,200),  pk7(20,100,100,100,100,100,100),  7'h7f,      266, 3'b101, 0, 266, 7'b0000000};
        tbl[2] = '{100, 20, pk8(105,77,76,200,200,104,104),   pk7(29,29,29,100,100,2,1),        7'h7f,      27,  3'b011, 1, 27,  7'b0100010};
        tbl[3] = '{255, 20, pk8(200,200,200,240,200,200,0),   pk7(100,100,100,20,100,100,20),   7'h7f,      271, 3'b110, 3, 271, 7'b0001000};
        tbl[4] = '{20,  20, pk8(10,200,200,200,30,10,200),    pk7(20,100,100,100,20,30,100),    7'h7f,      -1,  3'b000, 4, 0,   7'b0000001};
        tbl[5] = '{20,  20, pk8(10,200,200,200,200,200,200),  pk7(20,100,100,100,100,100,100),  7'b1111110, 266, 3'b010, 0, 0,   7'b0000000};
        tbl[6] = '{20,  20, pk8(10,10,10,10,10,10,10),        pk7(20,20,20,20,20,20,20),        7'h7f,      -1,  3'b000, 6, 266, 7'b1111111};
        tbl[7] = '{20,  20, pk8(10,10,10,10,10,10,10),        pk7(20,20,20,20,20,20,20),        7'b0101010, -1,  3'b000, 0, 0,   7'b0101010};
        tbl[8] = '{20,  20, pk8(20,200,200,200,200,200,200),  pk7(29,100,100,100,100,100,100),  7'h7f,      -1,  3'b000, 0, 4,   7'b0000000};
        tbl[9] = '{100, 20, pk8(77,200,200,200,200,200,200),  pk7(2,100,100,100,100,100,100),   7'h7f,      -1,  3'b000, 0, 783, 7'b0000001};

        for (int t = 0; t < 10; t++) begin
            v = tbl[t];
            loadVec(v);
            drive();
            if (v.romAddr >= 0) rom[v.romAddr] = v.romVal;
            doScan(1'b0, 1'b0);
            check($sformatf("vec%0d_collisionBS", t), 32'(seenVec), 32'(v.expVec));
            check($sformatf("vec%0d_addr_b%0d", t, v.chkBub), 32'(seenAddr[v.chkBub]), v.chkAddr);
            for (int i = 0; i < 7; i++)
                check($sformatf("vec%0d_model_addr_b%0d", t, i), 32'(seenAddr[i]), modelAddr(i));
            if (v.romAddr >= 0) rom[v.romAddr] = baseRom(v.romAddr);
        end

        // Enable mask plus start pulses mid-scan and in the DONE cycle.
        loadVec(tbl[0]);
        enI = 7'b1111110;
        drive();
        doScan(1'b1, 1'b0);
        check("masked_midstart_collisionBS", 32'(seenVec), 0);

        // Reset in the middle of a scan discards the result.
        loadVec(tbl[0]);
        drive();
        doScan(1'b0, 1'b0);
        check("pre_reset_result", 32'(seenVec), 1);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("midreset_collisionBS", 32'(collisionBS), 0);
        check("midreset_busy", 32'(busy), 0);
        check("midreset_done", 32'(done), 0);
        check("midreset_rom_address", 32'(rom_address), 0);
        @(negedge clock);
        resetn = 1'b1;
        doScan(1'b0, 1'b0);
        check("post_reset_collisionBS", 32'(seenVec), 1);

        // Random scenes, bubbles biased to land around the swimmer centre.
        for (int r = 0; r < 40; r++) begin
            sxI = $urandom_range(0, 255);
            syI = $urandom_range(0, 127);
            enI = 7'($urandom);
            for (int i = 0; i < 7; i++) begin
                bxI[i] = sxI + 4 - ($urandom_range(0, 33) - 3);
                byI[i] = syI + 9 - ($urandom_range(0, 33) - 3);
                if (bxI[i] < 0 || bxI[i] > 255) bxI[i] = $urandom_range(0, 255);
                if (byI[i] < 0 || byI[i] > 127) byI[i] = $urandom_range(0, 127);
            end
            drive();
            doScan(1'b0, 1'b1);
            check($sformatf("rand%0d_collisionBS", r), 32'(seenVec), 32'(modelVec()));
            for (int i = 0; i < 7; i++)
                check($sformatf("rand%0d_addr_b%0d", r, i), 32'(seenAddr[i]), modelAddr(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Time-multiplexes one shared bubble-sprite ROM and one collision evaluator across the 7 bubbles. Replaces seven parallel ROM/checker instances.
- Runs once per `start` pulse, normally once per frame after object positions update.
- Scans bubbles 0..6 in order and checks whether the swimmer centre point lands on a non-transparent bubble pixel.
- Publishes a registered 7-bit collision vector together with a one-cycle `done` pulse.

Parameters:
- BUBBLES, 7, number of bubbles scanned; the vector width equals this.
- BSIZE, 28, bubble sprite edge length in pixels; valid offsets are 0..BSIZE-1.
- CX_OFF, 4, swimmer centre X offset from the swimmer origin.
- CY_OFF, 9, swimmer centre Y offset from the swimmer origin.
- TRANSP, 3'b101, ROM colour treated as transparent (pink).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- swimmerX  in  8  swimmer origin X.
- swimmerY  in  7  swimmer origin Y.
- bubbleX  in  56  packed bubble X positions; bubble i occupies [8i+7:8i].
- bubbleY  in  49  packed bubble Y positions; bubble i occupies [7i+6:7i].
- bubble_en  in  7  per-bubble enable; a disabled bubble always reports 0.
- rom_address  out  10  registered address to the shared bubble ROM.
- rom_data  in  3  ROM colour; valid one cycle after the ROM samples rom_address.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse; `collisionBS` updates in the same cycle.
- collisionBS  out  7  bit i is 1 when the swimmer centre lies on an opaque pixel of bubble i.

Behaviour:
- Reset (resetn low, asynchronous):
  - State returns to IDLE.
  - rom_address=0, busy=0, done=0, collisionBS=0, shadow vector=0, idx=0.
  - Reset asserted mid-scan discards the partial result.
- States: IDLE, ISSUE, WAIT, EVAL, DONE.
- IDLE:
  - On `start`, snapshot all coordinates and bubble_en into registers.
  - Set idx=0, clear the shadow vector, set busy=1, go to ISSUE.
  - Input changes after acceptance do not affect the scan.
- ISSUE (bubble idx):
  - Compute in 10-bit signed arithmetic: cx={0,swimmerX}+CX_OFF and cy={0,swimmerY}+CY_OFF.
  - dx=cx-bubbleX[idx], dy=cy-bubbleY[idx].
  - inbox = (0 <= dx <= BSIZE-1) and (0 <= dy <= BSIZE-1) and bubble_en[idx]. Register inbox.
  - rom_address <= dy*BSIZE+dx when inbox is true, otherwise 0.
  - Go to WAIT.
- WAIT: the ROM samples rom_address. Go to EVAL.
- EVAL:
  - shadow[idx] <= inbox and (rom_data != TRANSP).
  - If idx = BUBBLES-1, go to DONE; otherwise idx <= idx+1 and go to ISSUE.
- DONE:
  - collisionBS <= shadow, done <= 1 for exactly one cycle, busy <= 0.
  - Go to IDLE.
- Latency: 3 cycles per bubble.
  - collisionBS and done become visible after the 22nd rising edge following the edge that accepted `start`.
  - A new `start` may be accepted the cycle after `done`.
- collisionBS holds its value between scans. It changes only in DONE or on reset.
- `start` outside IDLE is ignored, including in the DONE cycle. It is not queued.
- Boundaries:
  - dx=0 and dx=BSIZE-1 are inside; dx=BSIZE and dx=-1 are outside. The same applies to dy.
  - A swimmer at X=255 gives cx=259 and must not wrap.
- rom_address range is 0..BSIZE*BSIZE-1 (0..783). Out-of-box bubbles never issue a non-zero address.

Test Plan:
1. Centre hit:
   - Stimulus: swimmer (20,20) gives centre (24,29); bubble0 at (10,20); ROM at address 9*28+14=266 holds 3'b010; all bubbles enabled, others far away (200,100).
   - Expected: after 22 edges, done=1 and collisionBS=7'b0000001; rom_address=266 observed during WAIT of bubble0.
2. Transparent pixel:
   - Stimulus: as scenario 1 but ROM[266]=3'b101.
   - Expected: collisionBS=0.
3. Edges:
   - Stimulus: bubble1 placed so dx=27, dy=0 (opaque pixel); bubble2 placed so dx=28.
   - Expected: bit1=1, bit2=0, and address 27 is issued for bubble1.
4. Negative and wrap cases:
   - Stimulus: swimmerX=255 with bubble3 at X=240 (dx=19, inside, opaque), plus bubble4 at X=30 with swimmerX=20 (dx=-6).
   - Expected: bit3=1, bit4=0.
5. Enable masking and busy:
   - Stimulus: bubble_en=7'b1111110 with scenario 1 positions; pulse `start` again mid-scan.
   - Expected: bit0=0; exactly one done pulse; busy falls in the done cycle.
6. Reset mid-scan:
   - Stimulus: assert resetn=0 at cycle 10 after a prior result of 7'b0000001.
   - Expected: immediately collisionBS=0, busy=0, done=0; after release, the next `start` completes normally.
